mux_nto1_rr_reg: RTL and testbench
==================================

Name: mux_nto1_rr_reg

Overview:
- Parametrised successor to the team's fixed 8:1 single-bit mux.
- Selects one of N_CH channels, each DATA_W bits wide, with a per-channel valid/ready handshake.
- Two selection modes: externally selected channel, or round-robin arbitration.
- Registered output stage with its own valid/ready handshake. Sits between multiple producers and a single downstream consumer in the synthetic datapath blocks.

Parameters:
- N_CH, 8, number of input channels (2..64).
- DATA_W, 8, data width per channel in bits (>=1).
- SEL_W, $clog2(N_CH), width of the channel index; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  N_CH  per-channel data valid.
- in_ready  output  N_CH  per-channel accept; one-hot or zero.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  DATA_W  registered selected data.
- out_ch  output  SEL_W  index of the channel that out_data came from.
- out_valid  output  1  output register holds data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
  - in_ready=0 while rst is high.
- Transfers:
  - Input transfer on channel i: in_valid[i] & in_ready[i] at a rising edge.
  - Output transfer: out_valid & out_ready.
- Slot free: slot_free = !out_valid | out_ready. Full throughput is one transfer per cycle; there is no bubble when downstream is always ready.
- Grant in fixed mode (mode=0):
  - grant = onehot(sel) when in_valid[sel] is set and sel < N_CH; otherwise no grant.
  - An out-of-range sel (non-power-of-2 N_CH) never grants, and no X or garbage data is taken.
- Grant in round-robin mode (mode=1):
  - grant goes to the first i with in_valid[i] set, scanning ptr, ptr+1, ..., wrapping modulo N_CH (not modulo 2^SEL_W).
- Ready generation: in_ready = grant & {N_CH{slot_free}}. Combinational from in_valid, mode, sel, ptr, out_valid and out_ready. No combinational path from in_valid[i] to in_ready[j] for j != i except through the arbitration.
- On an input transfer from channel g:
  - Next cycle: out_data = channel g data, out_ch = g, out_valid = 1.
  - Latency is one cycle from input transfer to out_valid.
- Pointer update:
  - In mode=1, on a transfer from channel g: ptr <= (g == N_CH-1) ? 0 : g+1.
  - ptr does not change on cycles without a transfer, nor in mode=0.
- Output drain: output transfer without a new input transfer -> out_valid <= 0. out_data and out_ch hold their last values (no clearing).
- Stall: while out_valid & !out_ready, out_data and out_ch are stable and in_ready is all zeros.
- Mode and sel changes: sampled every cycle and take effect on the next grant decision. A word already in the output register is unaffected. ptr is retained across mode switches.
- Simultaneous drain and load in the same cycle: the new word replaces the old; out_valid stays 1.
- Reset mid-operation: any buffered word is discarded; no output transfer occurs after rst asserts.

Test Plan:
- Reset then idle: after rst, out_valid=0, out_data=0, out_ch=0, in_ready=0. With all in_valid=0 for 10 cycles, out_valid stays 0.
- Fixed mode sweep (N_CH=8, DATA_W=8, out_ready=1): channel i holds 8'hA0+i, all valid, sel steps 0..7 -> out_data sequence A0..A7, out_ch 0..7, each one cycle after its sel. in_ready is onehot(sel) each cycle.
- Round-robin fairness: mode=1, all 8 channels continuously valid, out_ready=1 -> grants 0,1,...,7,0,1, one per cycle. Then with only channels 2 and 5 valid -> alternating 2,5,2,5.
- Backpressure: mode=1, out_ready=0 for 4 cycles after the first load -> out_data and out_ch frozen, in_ready=0. On release, one output transfer per cycle resumes with no lost or duplicated word (scoreboard per channel).
- Wrap and boundary: N_CH=5, mode=1, only channel 4 valid, then only channel 0 -> ptr wraps to 0. In mode=0 with sel=6 -> no grant, in_ready=0.
- Async reset mid-stall: with out_valid=1 and out_ready=0, rst pulses between clock edges -> out_valid=0 immediately. After release, the first grant in mode=1 starts from channel 0.

Source files
------------

// File: rtl/mux_nto1_rr_reg.sv
// N_CH-to-1 channel mux with per-channel valid/ready, fixed-select or round-robin
// arbitration, and a single registered output slot with its own valid/ready.
module mux_nto1_rr_reg #(
    parameter  int N_CH   = 8,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [DATA_W-1:0] r_data_p1;
    logic [SEL_W-1:0]  r_ch_p1;
    logic              r_vld_p1;
    logic [SEL_W-1:0]  r_ptr;

    logic              w_slot_free;
    logic              w_fix_hit;
    logic [N_CH-1:0]   w_rr_rot;
    logic              w_rr_hit;
    logic [SEL_W-1:0]  w_rr_off;
    logic [SEL_W:0]    w_rr_sum;
    logic [SEL_W-1:0]  w_rr_idx;
    logic              w_gnt_any;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic [N_CH-1:0]   w_grant;
    logic              w_xfer;
    logic [DATA_W-1:0] w_gnt_data;
    logic [SEL_W-1:0]  w_ptr_nxt;

    // The slot can take a word when empty or when its current word leaves this cycle.
    assign w_slot_free = !r_vld_p1 || out_ready;

    // Fixed mode: indices at or above N_CH (non-power-of-2 N_CH) never grant.
    assign w_fix_hit = ({1'b0, sel} < (SEL_W+1)'(N_CH)) && in_valid[sel];

    // Round-robin: rotate valids so bit 0 is the pointer channel, then take the lowest set bit.
    assign w_rr_rot = N_CH'({in_valid, in_valid} >> r_ptr);

    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_off = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_rr_rot[k]) begin
                w_rr_hit = 1'b1;
                w_rr_off = SEL_W'(k);
            end
        end
    end

    // Wrap modulo N_CH rather than 2^SEL_W.
    assign w_rr_sum = {1'b0, r_ptr} + {1'b0, w_rr_off};
    assign w_rr_idx = (w_rr_sum >= (SEL_W+1)'(N_CH)) ? SEL_W'(w_rr_sum - (SEL_W+1)'(N_CH))
                                                     : w_rr_sum[SEL_W-1:0];

    assign w_gnt_any = mode ? w_rr_hit : w_fix_hit;
    assign w_gnt_idx = mode ? w_rr_idx : sel;

    always_comb begin
        w_grant = '0;
        if (w_gnt_any) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == w_gnt_idx) begin
                w_gnt_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_ready  = w_grant & {N_CH{w_slot_free && !rst}};
    assign w_xfer    = w_gnt_any && w_slot_free;
    assign w_ptr_nxt = (w_gnt_idx == SEL_W'(N_CH - 1)) ? '0 : w_gnt_idx + SEL_W'(1);

    // Stage p1: output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_ch_p1   <= '0;
            r_ptr     <= '0;
        end else begin
            if (w_xfer) begin
                r_vld_p1  <= 1'b1;
                r_data_p1 <= w_gnt_data;
                r_ch_p1   <= w_gnt_idx;
            end else if (out_ready) begin
                r_vld_p1  <= 1'b0;
            end
            if (w_xfer && mode) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign out_data  = r_data_p1;
    assign out_ch    = r_ch_p1;
    assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_mux_nto1_rr_reg.sv
// Scoreboard bench: two instances (N_CH=8 and N_CH=5) driven from one stimulus
// process; a separate monitor pops expected words as the DUT presents them.
module tb_mux_nto1_rr_reg;

    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [2:0]    ch;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [7:0]    t_valid [2];
    logic [DW-1:0] t_dat   [2][8];
    logic          t_mode  [2];
    logic [2:0]    t_sel   [2];
    logic          t_ordy  [2];

    logic [8*DW-1:0] w_data0;
    logic [5*DW-1:0] w_data1;
    logic [7:0]      rdy0;
    logic [4:0]      rdy1;
    logic [DW-1:0]   od0, od1;
    logic [2:0]      oc0, oc1;
    logic            ov0, ov1;

    for (genvar i = 0; i < 8; i++) begin : g_pack0
        assign w_data0[i*DW +: DW] = t_dat[0][i];
    end
    for (genvar i = 0; i < 5; i++) begin : g_pack1
        assign w_data1[i*DW +: DW] = t_dat[1][i];
    end

    mux_nto1_rr_reg #(.N_CH(8), .DATA_W(DW)) u_dut8 (
        .clk(clk), .rst(rst), .in_data(w_data0), .in_valid(t_valid[0]),
        .in_ready(rdy0), .mode(t_mode[0]), .sel(t_sel[0]), .out_data(od0),
        .out_ch(oc0), .out_valid(ov0), .out_ready(t_ordy[0])
    );

    mux_nto1_rr_reg #(.N_CH(5), .DATA_W(DW)) u_dut5 (
        .clk(clk), .rst(rst), .in_data(w_data1), .in_valid(t_valid[1][4:0]),
        .in_ready(rdy1), .mode(t_mode[1]), .sel(t_sel[1]), .out_data(od1),
        .out_ch(oc1), .out_valid(ov1), .out_ready(t_ordy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_ptr [2];
    bit   m_vld [2];
    int   n_ch  [2];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] act_rdy(int d);
        return (d == 0) ? rdy0 : {3'b000, rdy1};
    endfunction

    // Reference: which channel the spec's rules grant this cycle, -1 for none.
    function automatic int model_grant(int d);
        int c;
        if (!t_mode[d]) begin
            if (int'(t_sel[d]) < n_ch[d] && t_valid[d][t_sel[d]]) return int'(t_sel[d]);
            return -1;
        end
        for (int k = 0; k < n_ch[d]; k++) begin
            c = (m_ptr[d] + k) % n_ch[d];
            if (t_valid[d][c]) return c;
        end
        return -1;
    endfunction

    task automatic set_in(int d, logic [7:0] v, logic m, logic [2:0] s, logic r);
        t_valid[d] = v;
        t_mode[d]  = m;
        t_sel[d]   = s;
        t_ordy[d]  = r;
    endtask

    task automatic rand_data(int d);
        for (int i = 0; i < 8; i++) t_dat[d][i] = DW'($urandom);
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0;
            m_vld[d] = 1'b0;
        end
    endtask

    // Called after inputs are set (between edges); checks in_ready, then clocks the model.
    task automatic cycle();
        int   g [2];
        bit   x [2];
        exp_t e;
        #1;
        for (int d = 0; d < 2; d++) begin
            g[d] = model_grant(d);
            x[d] = (g[d] >= 0) && (!m_vld[d] || t_ordy[d]);
            chk($sformatf("in_ready[dut%0d]", d), 64'(act_rdy(d)),
                x[d] ? (64'(1) << g[d]) : 64'(0));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (x[d]) begin
                e.d  = t_dat[d][g[d]];
                e.ch = 3'(g[d]);
                if (d == 0) q0.push_back(e); else q1.push_back(e);
                if (t_mode[d]) m_ptr[d] = (g[d] + 1) % n_ch[d];
                m_vld[d] = 1'b1;
            end else if (t_ordy[d]) begin
                m_vld[d] = 1'b0;
            end
        end
        #2;
    endtask

    task automatic mon(int d);
        logic          ov;
        logic [DW-1:0] od;
        logic [2:0]    oc;
        exp_t          e;
        int            qs;
        ov = (d == 0) ? ov0 : ov1;
        od = (d == 0) ? od0 : od1;
        oc = (d == 0) ? oc0 : oc1;
        qs = (d == 0) ? q0.size() : q1.size();
        chk($sformatf("out_valid[dut%0d]", d), 64'(ov), 64'(m_vld[d]));
        if (ov) begin
            if (qs == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_unexpected[dut%0d]: got data %0h ch %0d expected no word", d, od, oc);
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                chk($sformatf("out_data[dut%0d]", d), 64'(od), 64'(e.d));
                chk($sformatf("out_ch[dut%0d]", d), 64'(oc), 64'(e.ch));
                if (t_ordy[d]) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int d = 0; d < 2; d++) mon(d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_ch[0] = 8;
        n_ch[1] = 5;
        model_clear();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            set_in(d, 8'hFF, 1'b1, 3'd0, 1'b1);
            rand_data(d);
        end
        repeat (2) @(posedge clk);
        #2;
        chk("reset out_valid", 64'({ov0, ov1}), 64'(0));
        chk("reset out_data",  64'({od0, od1}), 64'(0));
        chk("reset out_ch",    64'({oc0, oc1}), 64'(0));
        chk("reset in_ready",  64'({rdy0, rdy1}), 64'(0));
        for (int d = 0; d < 2; d++) set_in(d, 8'h00, 1'b0, 3'd0, 1'b1);
        rst = 1'b0;
        repeat (10) cycle();

        // Fixed-mode sweep on the 8-channel instance.
        for (int i = 0; i < 8; i++) t_dat[0][i] = DW'(8'hA0 + i);
        for (int i = 0; i < 8; i++) begin
            set_in(0, 8'hFF, 1'b0, 3'(i), 1'b1);
            cycle();
        end

        // Round-robin fairness, then only channels 2 and 5.
        for (int i = 0; i < 16; i++) begin
            set_in(0, 8'hFF, 1'b1, 3'd0, 1'b1);
            cycle();
        end
        for (int i = 0; i < 6; i++) begin
            set_in(0, 8'b0010_0100, 1'b1, 3'd0, 1'b1);
            cycle();
        end

        // Backpressure: load one word, stall four cycles, then release.
        rand_data(0);
        set_in(0, 8'hFF, 1'b1, 3'd0, 1'b1);
        cycle();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 8'hFF, 1'b1, 3'd0, 1'b0);
            cycle();
        end
        for (int i = 0; i < 8; i++) begin
            rand_data(0);
            set_in(0, 8'hFF, 1'b1, 3'd0, 1'b1);
            cycle();
        end
        set_in(0, 8'h00, 1'b1, 3'd0, 1'b1);
        cycle();

        // Wrap on the 5-channel instance, then out-of-range selects.
        rand_data(1);
        set_in(1, 8'b0001_0000, 1'b1, 3'd0, 1'b1);
        cycle();
        set_in(1, 8'b0000_0001, 1'b1, 3'd0, 1'b1);
        cycle();
        set_in(1, 8'b0001_0001, 1'b1, 3'd0, 1'b1);
        cycle();
        for (int s = 5; s < 8; s++) begin
            set_in(1, 8'hFF, 1'b0, 3'(s), 1'b1);
            cycle();
        end
        set_in(1, 8'h00, 1'b0, 3'd0, 1'b1);
        cycle();

        // Asynchronous reset while both outputs are stalled.
        for (int d = 0; d < 2; d++) set_in(d, 8'hFF, 1'b1, 3'd0, 1'b1);
        cycle();
        for (int d = 0; d < 2; d++) set_in(d, 8'hFF, 1'b1, 3'd0, 1'b0);
        cycle();
        cycle();
        chk("stall before reset", 64'({ov0, ov1}), 64'(2'b11));
        rst = 1'b1;
        #1;
        chk("async reset out_valid", 64'({ov0, ov1}), 64'(0));
        chk("async reset in_ready",  64'({rdy0, rdy1}), 64'(0));
        rst = 1'b0;
        model_clear();
        for (int d = 0; d < 2; d++) set_in(d, 8'hFF, 1'b1, 3'd0, 1'b1);
        cycle();
        cycle();

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                rand_data(d);
                set_in(d, 8'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       $urandom_range(0, 3) != 0);
            end
            cycle();
        end

        for (int d = 0; d < 2; d++) set_in(d, 8'h00, 1'b1, 3'd0, 1'b1);
        repeat (3) cycle();
        chk("dut0 scoreboard empty", 64'(q0.size()), 64'(0));
        chk("dut1 scoreboard empty", 64'(q1.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
